// File: rtl/bus_port_fifo.sv
// bus_port_fifo: per-device transmit FIFO between one bus device and the
// bus arbiter. The device pushes opaque packets {dest_id, payload}. The
// arbiter sees pndng, reads the head packet on D_pop (first-word
// fall-through) and dequeues it with pop. Occupancy is tracked by an
// explicit counter so DEPTH need not be a power of two. Sticky error flags
// record dropped pushes (overflow) and pops while empty (underflow).
module bus_port_fifo #(
  parameter int PCKG_SZ   = 24,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  localparam int CNT_W    = $clog2(DEPTH + 1),
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  // device side
  input  logic               dev_push,
  input  logic [PCKG_SZ-1:0] dev_data,
  output logic               full,
  output logic               almost_full,
  // arbiter side
  output logic               pndng,
  input  logic               pop,
  output logic [PCKG_SZ-1:0] D_pop,
  // status
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  output logic               underflow,
  input  logic               clr_err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  // Circular-buffer pointer advance with explicit wrap at DEPTH-1.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == LAST_C) ptr_next = '0;
    else             ptr_next = p + PTR_W'(1);
  endfunction

  logic [PCKG_SZ-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic empty;
  logic is_full;
  logic pop_ok;
  logic push_ok;
  logic push_drop;
  logic pop_bad;

  // Accept/reject decisions. A push into a full FIFO is accepted only when a
  // real pop frees the head slot on the same edge; a pop on an empty FIFO is
  // never accepted, even if a push arrives in the same cycle (no bypass).
  always_comb begin
    empty     = (count_q == '0);
    is_full   = (count_q == DEPTH_C);
    pop_ok    = pop && !empty;
    pop_bad   = pop && empty;
    push_ok   = dev_push && (!is_full || pop_ok);
    push_drop = dev_push && !push_ok;
  end

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (pop_ok)  rd_ptr_d = ptr_next(rd_ptr_q);
    if (push_ok) wr_ptr_d = ptr_next(wr_ptr_q);

    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);

    // Clear first so a new error in the same cycle wins.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push_drop) overflow_d  = 1'b1;
    if (pop_bad)   underflow_d = 1'b1;
  end

  // Control state; asynchronous reset discards all stored packets at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Packet storage; contents are not reset, validity comes from count_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= dev_data;
  end

  // Output decode from registered state only; D_pop is forced to zero when
  // empty so stale memory never leaks onto the arbiter bus.
  always_comb begin
    count       = count_q;
    pndng       = !empty;
    full        = is_full;
    almost_full = (count_q >= AF_C);
    overflow    = overflow_q;
    underflow   = underflow_q;
    D_pop       = empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_bus_port_fifo.sv
// Directed testbench for bus_port_fifo (PCKG_SZ=24, DEPTH=8, AF_THRESH=6).
module tb_bus_port_fifo;

  logic        clk;
  logic        reset;
  logic        dev_push;
  logic [23:0] dev_data;
  logic        full;
  logic        almost_full;
  logic        pndng;
  logic        pop;
  logic [23:0] D_pop;
  logic [3:0]  count;
  logic        overflow;
  logic        underflow;
  logic        clr_err;

  int errs   = 0;
  int checks = 0;

  logic [23:0] exp_q[$];
  logic [23:0] w;

  bus_port_fifo #(.PCKG_SZ(24), .DEPTH(8), .AF_THRESH(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .dev_push   (dev_push),
    .dev_data   (dev_data),
    .full       (full),
    .almost_full(almost_full),
    .pndng      (pndng),
    .pop        (pop),
    .D_pop      (D_pop),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [23:0] d);
    dev_push = 1'b1;
    dev_data = d;
    tick();
    dev_push = 1'b0;
  endtask

  task automatic pop_word();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    dev_push = 1'b0;
    dev_data = '0;
    pop      = 1'b0;
    clr_err  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_count", count, 0);
    check("rst_pndng", pndng, 0);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_dpop", D_pop, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    reset = 1'b0;
    tick();

    // 1: single push / pop
    push_word(24'h05ABCD);
    check("t1_pndng", pndng, 1);
    check("t1_dpop", D_pop, 24'h05ABCD);
    check("t1_count", count, 1);
    pop_word();
    check("t1_pndng_after_pop", pndng, 0);
    check("t1_dpop_after_pop", D_pop, 0);
    check("t1_count_after_pop", count, 0);

    // 2: fill to full, overflow on 9th push, drain in order
    for (int i = 0; i < 8; i++) begin
      w = {8'(i + 1), 16'hA000 + 16'(i)};
      push_word(w);
      check("t2_count", count, i + 1);
      check("t2_af", almost_full, (i + 1 >= 6) ? 1 : 0);
      check("t2_full", full, (i + 1 == 8) ? 1 : 0);
    end
    check("t2_ovf_before", overflow, 0);
    push_word(24'hFFFFFF);
    check("t2_ovf", overflow, 1);
    check("t2_count_after_drop", count, 8);
    check("t2_head_after_drop", D_pop, 24'h01A000);
    for (int i = 0; i < 8; i++) begin
      w = {8'(i + 1), 16'hA000 + 16'(i)};
      check("t2_drain", D_pop, w);
      pop_word();
    end
    check("t2_empty", pndng, 0);
    check("t2_unf", underflow, 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t2_ovf_clr", overflow, 0);

    // 3: fill, pop 3, push 3 -> wrap, read back in FIFO order
    for (int i = 0; i < 8; i++) begin
      w = {8'h30, 16'(i)};
      exp_q.push_back(w);
      push_word(w);
    end
    for (int i = 0; i < 3; i++) begin
      check("t3_pop_head", D_pop, exp_q.pop_front());
      pop_word();
    end
    check("t3_count5", count, 5);
    for (int i = 0; i < 3; i++) begin
      w = {8'h3C, 16'hBEE0 + 16'(i)};
      exp_q.push_back(w);
      push_word(w);
    end
    check("t3_full", full, 1);
    check("t3_ovf", overflow, 0);

    // 4: full, simultaneous push+pop
    dev_push = 1'b1;
    dev_data = 24'h011111;
    pop      = 1'b1;
    tick();
    dev_push = 1'b0;
    pop      = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(24'h011111);
    check("t4_count", count, 8);
    check("t4_ovf", overflow, 0);
    check("t4_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      check("t4_drain", D_pop, exp_q.pop_front());
      pop_word();
    end
    check("t4_empty", count, 0);
    check("t4_last_was_new", exp_q.size(), 0);

    // 5: empty, simultaneous push+pop
    dev_push = 1'b1;
    dev_data = 24'h0A5555;
    pop      = 1'b1;
    tick();
    dev_push = 1'b0;
    pop      = 1'b0;
    check("t5_count", count, 1);
    check("t5_unf", underflow, 1);
    check("t5_dpop", D_pop, 24'h0A5555);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t5_unf_clr", underflow, 0);
    check("t5_retained", D_pop, 24'h0A5555);
    pop_word();
    // clear and new underflow in the same cycle: set wins
    clr_err = 1'b1;
    pop     = 1'b1;
    tick();
    clr_err = 1'b0;
    pop     = 1'b0;
    check("t5_set_wins", underflow, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("t5_unf_clr2", underflow, 0);

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) push_word({8'h60, 16'(i)});
    check("t6_count5", count, 5);
    check("t6_af_below", almost_full, 0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_count", count, 0);
    check("t6_async_pndng", pndng, 0);
    check("t6_async_dpop", D_pop, 0);
    #1;
    reset = 1'b0;
    tick();
    check("t6_after_rst", pndng, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
